// File: rtl/t07_fpu_pkg.sv
// rtl/t07_fpu_pkg.sv - FPUOp encodings, buffered result record and destination decode for the FPU writeback path.
package t07_fpu_pkg;

  localparam int FPU_XLEN = 32;

  localparam logic [4:0] FMADD     = 5'd0;
  localparam logic [4:0] FMSUB     = 5'd1;
  localparam logic [4:0] FNMSUB    = 5'd2;
  localparam logic [4:0] FNMADD    = 5'd3;
  localparam logic [4:0] FADD      = 5'd4;
  localparam logic [4:0] FSUB      = 5'd5;
  localparam logic [4:0] FMUL      = 5'd6;
  localparam logic [4:0] FDIV      = 5'd7;
  localparam logic [4:0] FSQRT     = 5'd8;
  localparam logic [4:0] FSGNJ     = 5'd9;
  localparam logic [4:0] FSGNJN    = 5'd10;
  localparam logic [4:0] FSGNJX    = 5'd11;
  localparam logic [4:0] FMIN      = 5'd12;
  localparam logic [4:0] FMAX      = 5'd13;
  localparam logic [4:0] FCVT_S_W  = 5'd21;
  localparam logic [4:0] FCVT_S_WU = 5'd22;
  localparam logic [4:0] FCVT_W_S  = 5'd23;
  localparam logic [4:0] FCVT_WU_S = 5'd24;
  localparam logic [4:0] FMV_X_W   = 5'd25;
  localparam logic [4:0] FEQ       = 5'd26;
  localparam logic [4:0] FLT       = 5'd27;
  localparam logic [4:0] FLE       = 5'd28;
  localparam logic [4:0] FCLASS    = 5'd29;
  localparam logic [4:0] FMV_W_X   = 5'd30;

  typedef struct packed {
    logic [FPU_XLEN-1:0] data;
    logic [4:0]          rd;
    logic [4:0]          op;
    logic [4:0]          flags;
  } fpu_res_t;

  function automatic logic is_int_dest(input logic [4:0] op);
    case (op)
      FCVT_W_S, FCVT_WU_S, FMV_X_W, FEQ, FLT, FLE, FCLASS: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/t07_fpu_wb_fifo.sv
// rtl/t07_fpu_wb_fifo.sv - DEPTH-entry in-order FIFO of FPU results with occupancy count.
module t07_fpu_wb_fifo
  import t07_fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  fpu_res_t      wdata,
  output fpu_res_t      head,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fpu_res_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign head = mem[rd_ptr];

  // Callers only push when not full and pop when not empty; power-of-two DEPTH lets pointers wrap freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/t07_fpu_writeback.sv
// rtl/t07_fpu_writeback.sv - FPU result buffer retiring to the int/FP register files and accumulating sticky fflags.
// Optional head-entry forwarding outputs are enabled by defining T07_FPU_WB_FWD_EN.
module t07_fpu_writeback
  import t07_fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = FPU_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            res_valid_i,
  output logic            res_ready_o,
  input  logic [XLEN-1:0] res_data_i,
  input  logic [4:0]      res_rd_i,
  input  logic [4:0]      res_op_i,
  input  logic [4:0]      res_flags_i,
  output logic            int_we_o,
  input  logic            int_wgnt_i,
  output logic [4:0]      int_waddr_o,
  output logic [XLEN-1:0] int_wdata_o,
  output logic            fp_we_o,
  output logic [4:0]      fp_waddr_o,
  output logic [XLEN-1:0] fp_wdata_o,
  input  logic            fflags_wr_i,
  input  logic [4:0]      fflags_wdata_i,
  output logic [4:0]      fflags_o,
  output logic            empty_o
`ifdef T07_FPU_WB_FWD_EN
  ,
  output logic            fwd_valid_o,
  output logic [4:0]      fwd_rd_o,
  output logic            fwd_isfp_o,
  output logic [XLEN-1:0] fwd_data_o
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  fpu_res_t        in_res;
  fpu_res_t        head;
  logic [CW-1:0]   count;
  logic            empty;
  logic            live;
  logic            to_int;
  logic            push;
  logic            pop;
  logic [4:0]      retired_flags;

  assign in_res = '{data: res_data_i, rd: res_rd_i, op: res_op_i, flags: res_flags_i};

  t07_fpu_wb_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_res),
    .head  (head),
    .count (count)
  );

  assign empty       = (count == '0);
  assign empty_o     = empty;
  // Ready comes only from registered occupancy, so a pop on a full FIFO frees the slot next cycle.
  assign res_ready_o = (count != CW'(DEPTH));
  assign push        = res_valid_i && res_ready_o;

  // Writes are masked in the reset cycle so buffered entries being discarded never retire.
  assign live   = !empty && !rst;
  assign to_int = is_int_dest(head.op);

  assign int_we_o    = live && to_int;
  assign int_waddr_o = int_we_o ? head.rd : '0;
  assign int_wdata_o = int_we_o ? head.data : '0;
  assign fp_we_o     = live && !to_int;
  assign fp_waddr_o  = fp_we_o ? head.rd : '0;
  assign fp_wdata_o  = fp_we_o ? head.data : '0;

  assign pop           = fp_we_o || (int_we_o && int_wgnt_i);
  assign retired_flags = pop ? head.flags : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fflags_o <= '0;
    end else if (fflags_wr_i) begin
      fflags_o <= fflags_wdata_i | retired_flags;
    end else begin
      fflags_o <= fflags_o | retired_flags;
    end
  end

`ifdef T07_FPU_WB_FWD_EN
  assign fwd_valid_o = !empty;
  assign fwd_rd_o    = empty ? '0 : head.rd;
  assign fwd_isfp_o  = !empty && !to_int;
  assign fwd_data_o  = empty ? '0 : head.data;
`endif

endmodule
